// File: rtl/circuito_exp3_ativ2_pkg.sv
// rtl/circuito_exp3_ativ2_pkg.sv - shared width, terminal value and counter operation select
package circuito_exp3_ativ2_pkg;

  localparam int N = 4;

  typedef logic [N-1:0] count_t;

  localparam count_t MAX_COUNT = {N{1'b1}};

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  // Clear beats load beats count; a loaded value is never incremented in the same edge.
  function automatic op_t select_op(input logic zera, input logic carrega, input logic conta);
    if (zera)         return OP_CLEAR;
    else if (carrega) return OP_LOAD;
    else if (conta)   return OP_COUNT;
    else              return OP_HOLD;
  endfunction

endpackage

// File: rtl/circuito_exp3_ativ2_if.sv
// rtl/circuito_exp3_ativ2_if.sv - control, switch and flag bundle between control side and datapath
interface circuito_exp3_ativ2_if;
  import circuito_exp3_ativ2_pkg::*;

  logic   zera;
  logic   carrega;
  logic   conta;
  count_t chaves;
  logic   menor;
  logic   maior;
  logic   igual;
  logic   fim;
  count_t db_contagem;

  modport master (
    output zera, carrega, conta, chaves,
    input  menor, maior, igual, fim, db_contagem
  );

  modport slave (
    input  zera, carrega, conta, chaves,
    output menor, maior, igual, fim, db_contagem
  );

endinterface

// File: rtl/circuito_exp3_ativ2_comparador_85.sv
// rtl/circuito_exp3_ativ2_comparador_85.sv - 7485-style unsigned magnitude comparator
module circuito_exp3_ativ2_comparador_85
  import circuito_exp3_ativ2_pkg::*;
(
  input  count_t a,
  input  count_t b,
  output logic   lt,
  output logic   gt,
  output logic   eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/circuito_exp3_ativ2_contador_163.sv
// rtl/circuito_exp3_ativ2_contador_163.sv - 74163-style counter with clear/load/enable and ripple carry
module circuito_exp3_ativ2_contador_163
  import circuito_exp3_ativ2_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   zera,
  input  logic   carrega,
  input  logic   conta,
  input  count_t d,
  output count_t q,
  output logic   rco
);

  op_t op;

  always_comb begin
    op = select_op(zera, carrega, conta);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      case (op)
        OP_CLEAR: q <= '0;
        OP_LOAD:  q <= d;
        OP_COUNT: q <= q + count_t'(1);
        default:  q <= q;
      endcase
    end
  end

  // Conta doubles as ENT, so the carry is gated by it just like the 74163 RCO.
  assign rco = (q == MAX_COUNT) && conta;

endmodule

// File: rtl/circuito_exp3_ativ2.sv
// rtl/circuito_exp3_ativ2.sv - counter plus comparator datapath for the control-unit experiment
module circuito_exp3_ativ2
  import circuito_exp3_ativ2_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  circuito_exp3_ativ2_if.slave    bus
);

  count_t contagem;

  circuito_exp3_ativ2_contador_163 u_contador (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (bus.zera),
    .carrega (bus.carrega),
    .conta   (bus.conta),
    .d       (bus.chaves),
    .q       (contagem),
    .rco     (bus.fim)
  );

  circuito_exp3_ativ2_comparador_85 u_comparador (
    .a  (contagem),
    .b  (bus.chaves),
    .lt (bus.menor),
    .gt (bus.maior),
    .eq (bus.igual)
  );

  assign bus.db_contagem = contagem;

endmodule

// File: tb/tb_circuito_exp3_ativ2.sv
// tb/tb_circuito_exp3_ativ2.sv - vector table, directed corner sequences and random run against a count model
module tb_circuito_exp3_ativ2;

  logic clock;
  logic reset_n;

  circuito_exp3_ativ2_if bus ();

  circuito_exp3_ativ2 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int m_count = 0;

  typedef struct {
    logic       zera;
    logic       carrega;
    logic       conta;
    logic [3:0] chaves;
    logic       do_edge;
    int         exp_count;
    logic       exp_menor;
    logic       exp_maior;
    logic       exp_igual;
    logic       exp_fim;
  } vec_t;

  vec_t vecs[$];

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic z, input logic l, input logic c, input int ch);
    bus.zera    = z;
    bus.carrega = l;
    bus.conta   = c;
    bus.chaves  = 4'(ch);
  endtask

  // Reference: next count from the priority rules, evaluated on the inputs held across the edge.
  task automatic step();
    int nxt;
    if (bus.zera)         nxt = 0;
    else if (bus.carrega) nxt = int'(bus.chaves);
    else if (bus.conta)   nxt = (m_count + 1) % 16;
    else                  nxt = m_count;
    @(posedge clock);
    m_count = nxt;
    #1;
  endtask

  task automatic check_model(input string nm);
    int ch;
    ch = int'(bus.chaves);
    cmp({nm, "/count"}, int'(bus.db_contagem), m_count);
    cmp({nm, "/menor"}, int'(bus.menor), (m_count < ch) ? 1 : 0);
    cmp({nm, "/maior"}, int'(bus.maior), (m_count > ch) ? 1 : 0);
    cmp({nm, "/igual"}, int'(bus.igual), (m_count == ch) ? 1 : 0);
    cmp({nm, "/fim"},   int'(bus.fim),   (m_count == 15 && bus.conta) ? 1 : 0);
  endtask

  initial begin
    //               z  l  c  ch     edge cnt  lt gt eq fim
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  1'b0,  0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0,  1'b1,  0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd1,  1'b0,  0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd1,  1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd2,  1'b1,  2, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd9,  1'b1,  9, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd9,  1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd15, 1'b1, 15, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 15, 1'b0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd15, 1'b1,  0, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd5,  1'b1,  5, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd3,  1'b1,  5, 1'b0, 1'b1, 1'b0, 1'b0});

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3);
    #3;
    cmp("reset/count", int'(bus.db_contagem), 0);
    cmp("reset/fim", int'(bus.fim), 0);
    cmp("reset/menor", int'(bus.menor), 1);
    drive(1'b0, 1'b0, 1'b1, 0);
    #1;
    cmp("reset/igual", int'(bus.igual), 1);
    @(posedge clock);
    #1;
    cmp("reset/held_over_edge", int'(bus.db_contagem), 0);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0);
    m_count = 0;

    foreach (vecs[i]) begin
      drive(vecs[i].zera, vecs[i].carrega, vecs[i].conta, int'(vecs[i].chaves));
      if (vecs[i].do_edge) begin
        @(posedge clock);
        #1;
      end else begin
        #1;
      end
      cmp($sformatf("vec%0d/count", i), int'(bus.db_contagem), vecs[i].exp_count);
      cmp($sformatf("vec%0d/menor", i), int'(bus.menor), int'(vecs[i].exp_menor));
      cmp($sformatf("vec%0d/maior", i), int'(bus.maior), int'(vecs[i].exp_maior));
      cmp($sformatf("vec%0d/igual", i), int'(bus.igual), int'(vecs[i].exp_igual));
      cmp($sformatf("vec%0d/fim", i), int'(bus.fim), int'(vecs[i].exp_fim));
    end
    m_count = 5;

    // Count from 2 toward wrap with chaves=6
    drive(1'b0, 1'b1, 1'b0, 2);
    step();
    cmp("wrap/start", int'(bus.db_contagem), 2);
    drive(1'b0, 1'b0, 1'b1, 6);
    for (int k = 0; k < 11; k++) begin
      step();
      check_model($sformatf("wrap%0d", k));
      if (m_count >= 7) cmp($sformatf("wrap%0d/maior_hi", k), int'(bus.maior), 1);
    end
    cmp("wrap/at13", int'(bus.db_contagem), 13);
    step();
    step();
    cmp("wrap/at15", int'(bus.db_contagem), 15);
    cmp("wrap/fim_conta1", int'(bus.fim), 1);
    bus.conta = 1'b0;
    #1;
    cmp("wrap/fim_conta0", int'(bus.fim), 0);
    bus.conta = 1'b1;
    step();
    cmp("wrap/wrapped", int'(bus.db_contagem), 0);
    cmp("wrap/fim_after", int'(bus.fim), 0);
    cmp("wrap/menor_after", int'(bus.menor), 1);

    // Asynchronous reset between edges
    drive(1'b0, 1'b1, 1'b0, 5);
    step();
    cmp("areset/loaded", int'(bus.db_contagem), 5);
    drive(1'b0, 1'b0, 1'b1, 3);
    #3;
    reset_n = 1'b0;
    #1;
    cmp("areset/count", int'(bus.db_contagem), 0);
    cmp("areset/menor", int'(bus.menor), 1);
    cmp("areset/fim", int'(bus.fim), 0);
    #1;
    reset_n = 1'b1;
    m_count = 0;
    step();
    check_model("areset/resume");

    // Random run against the model
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));
      #1;
      check_model($sformatf("rnd%0d/pre", k));
      step();
      check_model($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
